// File: rtl/pipeline_stall_ctrl_pkg.sv
// Shared definitions for the pipeline hazard sequencer.
//   stall_bus_t   : one bit per pipeline register, index = stage below
//   STG_*         : bit positions of each register within a stall_bus_t
//   redir_state_e : branch-redirect FSM state codes
package pipeline_stall_ctrl_pkg;

  typedef logic [7:0] stall_bus_t;

  localparam int unsigned STG_PC     = 0;
  localparam int unsigned STG_IF     = 1;
  localparam int unsigned STG_IF_ID  = 2;
  localparam int unsigned STG_ID     = 3;
  localparam int unsigned STG_ID_EX  = 4;
  localparam int unsigned STG_EX     = 5;
  localparam int unsigned STG_EX_MEM = 6;
  localparam int unsigned STG_MEM_WB = 7;

  typedef enum logic [1:0] {
    StRun  = 2'd0,
    StPend = 2'd1
  } redir_state_e;

endpackage

// File: rtl/pipeline_stall_ctrl_stall_merge.sv
// Combinational merge of per-stage stall requests.
// The deepest requesting stage sets the freeze level K: registers 0..K hold and
// register K+1 (if any) loads a bubble so the stage ahead of the freeze drains.
// Ports:
//   if_stall_req, id_stall_req, ex_stall_req, mem_stall_req : stage requests
//   stall_vec  : bit k set -> register k holds
//   bubble_vec : bit k set -> register k loads NOP
module pipeline_stall_ctrl_stall_merge
  import pipeline_stall_ctrl_pkg::*;
(
  input  logic       if_stall_req,
  input  logic       id_stall_req,
  input  logic       ex_stall_req,
  input  logic       mem_stall_req,
  output stall_bus_t stall_vec,
  output stall_bus_t bubble_vec
);

  always_comb begin
    stall_vec  = '0;
    bubble_vec = '0;
    if (mem_stall_req) begin
      // K=7: whole pipe frozen, nothing beyond mem_wb to bubble.
      stall_vec = 8'hFF;
    end else if (ex_stall_req) begin
      stall_vec              = 8'h3F;
      bubble_vec[STG_EX_MEM] = 1'b1;
    end else if (id_stall_req) begin
      stall_vec             = 8'h0F;
      bubble_vec[STG_ID_EX] = 1'b1;
    end else if (if_stall_req) begin
      stall_vec             = 8'h03;
      bubble_vec[STG_IF_ID] = 1'b1;
    end
  end

endmodule

// File: rtl/pipeline_stall_ctrl.sv
// Central hazard sequencer for the 5-stage RV32I pipeline.
// Ports:
//   clk, rst                  : clock, synchronous active-high reset
//   *_stall_req               : per-stage stall requests
//   ex_branch_taken/target    : EX-resolved redirect
//   stall_sign / bubble_sign  : per-register hold / load-NOP controls
//   pc_redirect_valid/addr    : pc_reg loads addr when valid and stall_sign[0]=0
//   stall_cycles              : saturating count of cycles with pc frozen
//   hang                      : sticky watchdog, pc frozen HANG_LIMIT cycles in a row
module pipeline_stall_ctrl
  import pipeline_stall_ctrl_pkg::*;
#(
  parameter int unsigned CNT_W      = 32,
  parameter int unsigned HANG_LIMIT = 1024
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             if_stall_req,
  input  logic             id_stall_req,
  input  logic             ex_stall_req,
  input  logic             mem_stall_req,
  input  logic             ex_branch_taken,
  input  logic [31:0]      ex_branch_target,
  output logic [7:0]       stall_sign,
  output logic [7:0]       bubble_sign,
  output logic             pc_redirect_valid,
  output logic [31:0]      pc_redirect_addr,
  output logic [CNT_W-1:0] stall_cycles,
  output logic             hang
);

  localparam int unsigned RunW = $clog2(HANG_LIMIT + 1);

  stall_bus_t   merge_stall, merge_bubble, fsm_bubble;
  redir_state_e state_q, state_d;
  logic [31:0]  pend_addr_q, pend_addr_d;
  logic [CNT_W-1:0] stall_cycles_q, stall_cycles_d;
  logic [RunW-1:0]  run_cnt_q, run_cnt_d;
  logic         hang_q, hang_d;
  logic         branch_sampled;
  logic         pc_frozen;

  pipeline_stall_ctrl_stall_merge u_stall_merge (
    .if_stall_req  (if_stall_req),
    .id_stall_req  (id_stall_req),
    .ex_stall_req  (ex_stall_req),
    .mem_stall_req (mem_stall_req),
    .stall_vec     (merge_stall),
    .bubble_vec    (merge_bubble)
  );

  // All controls are forced quiet while reset is asserted.
  assign stall_sign = rst ? 8'h00 : merge_stall;
  assign pc_frozen  = stall_sign[STG_PC];

  // A branch only counts if EX is actually advancing this cycle.
  assign branch_sampled = ex_branch_taken & ~stall_sign[STG_EX];

  always_comb begin
    state_d           = state_q;
    pend_addr_d       = pend_addr_q;
    fsm_bubble        = '0;
    pc_redirect_valid = 1'b0;
    pc_redirect_addr  = '0;
    if (!rst) begin
      unique case (state_q)
        StRun: begin
          if (branch_sampled) begin
            fsm_bubble[STG_ID_EX] = 1'b1;
            if (!pc_frozen) begin
              pc_redirect_valid     = 1'b1;
              pc_redirect_addr      = ex_branch_target;
              fsm_bubble[STG_IF_ID] = 1'b1;
            end else begin
              pend_addr_d = ex_branch_target;
              state_d     = StPend;
            end
          end
        end
        StPend: begin
          pc_redirect_valid     = 1'b1;
          pc_redirect_addr      = pend_addr_q;
          // Anything fetched while the redirect waits is wrong-path.
          fsm_bubble[STG_IF_ID] = 1'b1;
          if (branch_sampled) begin
            // Younger branch wins; stay pending so its target lands next.
            pend_addr_d           = ex_branch_target;
            fsm_bubble[STG_ID_EX] = 1'b1;
          end else if (!pc_frozen) begin
            state_d = StRun;
          end
        end
        default: state_d = StRun;
      endcase
    end
  end

  // Stall wins over bubble on the same register.
  assign bubble_sign = rst ? 8'h00 : ((merge_bubble | fsm_bubble) & ~merge_stall);

  always_comb begin
    stall_cycles_d = stall_cycles_q;
    if (pc_frozen && (stall_cycles_q != '1)) begin
      stall_cycles_d = stall_cycles_q + CNT_W'(1);
    end
    run_cnt_d = '0;
    if (pc_frozen) begin
      run_cnt_d = (run_cnt_q == RunW'(HANG_LIMIT)) ? run_cnt_q : run_cnt_q + RunW'(1);
    end
    hang_d = hang_q | (run_cnt_d == RunW'(HANG_LIMIT));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= StRun;
      pend_addr_q    <= '0;
      stall_cycles_q <= '0;
      run_cnt_q      <= '0;
      hang_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      pend_addr_q    <= pend_addr_d;
      stall_cycles_q <= stall_cycles_d;
      run_cnt_q      <= run_cnt_d;
      hang_q         <= hang_d;
    end
  end

  assign stall_cycles = stall_cycles_q;
  assign hang         = hang_q;

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
module tb_pipeline_stall_ctrl;

  typedef struct {
    string       name;
    logic [7:0]  stall;
    logic [7:0]  bubble;
    logic        valid;
    logic [31:0] addr;
    logic        chk_cnt;
    logic [31:0] cnt;
    logic        chk_hang;
    logic        hang;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req, id_req, ex_req, mem_req, br;
  logic [31:0] tgt;
  logic [7:0]  stall_sign, bubble_sign, stall_sign2, bubble_sign2;
  logic        valid, valid2, hang, hang2;
  logic [31:0] addr, addr2, cnt;
  logic [1:0]  cnt2;

  exp_t sb[$];
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  pipeline_stall_ctrl #(.CNT_W(32), .HANG_LIMIT(8)) dut (
    .clk (clk), .rst (rst),
    .if_stall_req (if_req), .id_stall_req (id_req),
    .ex_stall_req (ex_req), .mem_stall_req (mem_req),
    .ex_branch_taken (br), .ex_branch_target (tgt),
    .stall_sign (stall_sign), .bubble_sign (bubble_sign),
    .pc_redirect_valid (valid), .pc_redirect_addr (addr),
    .stall_cycles (cnt), .hang (hang)
  );

  // Narrow counter instance to exercise saturation.
  pipeline_stall_ctrl #(.CNT_W(2), .HANG_LIMIT(1024)) dut_sat (
    .clk (clk), .rst (rst),
    .if_stall_req (if_req), .id_stall_req (id_req),
    .ex_stall_req (ex_req), .mem_stall_req (mem_req),
    .ex_branch_taken (br), .ex_branch_target (tgt),
    .stall_sign (stall_sign2), .bubble_sign (bubble_sign2),
    .pc_redirect_valid (valid2), .pc_redirect_addr (addr2),
    .stall_cycles (cnt2), .hang (hang2)
  );

  task automatic chk(input string nm, input string fld, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s.%s actual=%h required=%h", nm, fld, act, exp);
    end
  endtask

  // Monitor: outputs are sampled mid-cycle, one scoreboard entry per checked cycle.
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      logic [31:0] sat;
      e = sb.pop_front();
      chk(e.name, "stall", {24'h0, stall_sign}, {24'h0, e.stall});
      chk(e.name, "bubble", {24'h0, bubble_sign}, {24'h0, e.bubble});
      chk(e.name, "valid", {31'h0, valid}, {31'h0, e.valid});
      if (e.valid) chk(e.name, "addr", addr, e.addr);
      if (e.chk_cnt) begin
        sat = (e.cnt > 32'd3) ? 32'd3 : e.cnt;
        chk(e.name, "stall_cycles", cnt, e.cnt);
        chk(e.name, "stall_cycles_sat", {30'h0, cnt2}, sat);
      end
      if (e.chk_hang) chk(e.name, "hang", {31'h0, hang}, {31'h0, e.hang});
    end
  end

  task automatic step(input string nm, input logic r, input logic fi, input logic fd,
                      input logic fe, input logic fm, input logic b, input logic [31:0] t,
                      input logic [7:0] es, input logic [7:0] eb, input logic ev,
                      input logic [31:0] ea, input logic cc, input logic [31:0] ec,
                      input logic ch, input logic eh);
    exp_t e;
    rst = r; if_req = fi; id_req = fd; ex_req = fe; mem_req = fm; br = b; tgt = t;
    e.name = nm; e.stall = es; e.bubble = eb; e.valid = ev; e.addr = ea;
    e.chk_cnt = cc; e.cnt = ec; e.chk_hang = ch; e.hang = eh;
    sb.push_back(e);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; if_req = 0; id_req = 0; ex_req = 0; mem_req = 0; br = 0; tgt = '0;
    @(posedge clk);
    #1;
    // Reset masks requests and clears state.
    step("rst_mask", 1, 0, 0, 0, 1, 0, 0, 8'h00, 8'h00, 0, 0, 1, 0, 1, 0);
    // Full freeze on mem stall.
    for (int i = 0; i < 3; i++)
      step("mem_stall", 0, 0, 0, 0, 1, 0, 0, 8'hFF, 8'h00, 0, 0, 1, i, 1, 0);
    step("mem_release", 0, 0, 0, 0, 0, 0, 0, 8'h00, 8'h00, 0, 0, 1, 3, 1, 0);
    // id+if -> K=3.
    step("id_if", 0, 1, 1, 0, 0, 0, 0, 8'h0F, 8'h10, 0, 0, 1, 3, 1, 0);
    step("id_if_drop", 0, 0, 0, 0, 0, 0, 0, 8'h00, 8'h00, 0, 0, 1, 4, 1, 0);
    // Direct redirect.
    step("br_run", 0, 0, 0, 0, 0, 1, 32'h1000, 8'h00, 8'h14, 1, 32'h1000, 1, 4, 0, 0);
    step("br_run_next", 0, 0, 0, 0, 0, 0, 0, 8'h00, 8'h00, 0, 0, 1, 4, 0, 0);
    // Redirect held pending while fetch stalls.
    step("br_to_pend", 0, 1, 0, 0, 0, 1, 32'h200, 8'h03, 8'h14, 0, 0, 1, 4, 0, 0);
    for (int i = 0; i < 4; i++)
      step("pend_hold", 0, 1, 0, 0, 0, 0, 0, 8'h03, 8'h04, 1, 32'h200, 1, 5 + i, 0, 0);
    step("pend_land", 0, 0, 0, 0, 0, 0, 0, 8'h00, 8'h04, 1, 32'h200, 1, 9, 0, 0);
    step("pend_done", 0, 0, 0, 0, 0, 0, 0, 8'h00, 8'h00, 0, 0, 1, 9, 0, 0);
    // Branch ignored while EX is held.
    step("br_ex_stall", 0, 0, 0, 1, 0, 1, 32'h300, 8'h3F, 8'h40, 0, 0, 1, 9, 0, 0);
    step("br_ex_next", 0, 0, 0, 0, 0, 0, 0, 8'h00, 8'h00, 0, 0, 1, 10, 0, 0);
    // Watchdog at HANG_LIMIT=8.
    for (int i = 0; i < 8; i++)
      step("hang_stall", 0, 0, 0, 0, 1, 0, 0, 8'hFF, 8'h00, 0, 0, 1, 10 + i, 1, 0);
    step("hang_set", 0, 0, 0, 0, 0, 0, 0, 8'h00, 8'h00, 0, 0, 1, 18, 1, 1);
    step("hang_sticky", 0, 0, 0, 0, 0, 0, 0, 8'h00, 8'h00, 0, 0, 1, 18, 1, 1);
    step("hang_rst", 1, 0, 0, 0, 0, 0, 0, 8'h00, 8'h00, 0, 0, 1, 18, 1, 1);
    step("hang_cleared", 0, 0, 0, 0, 0, 0, 0, 8'h00, 8'h00, 0, 0, 1, 0, 1, 0);
    // Reset drops a pending redirect.
    step("br_pend2", 0, 1, 0, 0, 0, 1, 32'h400, 8'h03, 8'h14, 0, 0, 1, 0, 0, 0);
    step("rst_in_pend", 1, 1, 0, 0, 0, 0, 0, 8'h00, 8'h00, 0, 0, 1, 1, 1, 0);
    step("pend_dropped", 0, 0, 0, 0, 0, 0, 0, 8'h00, 8'h00, 0, 0, 1, 0, 1, 0);
    // Younger branch overwrites the pending target.
    step("yw_first", 0, 1, 0, 0, 0, 1, 32'h500, 8'h03, 8'h14, 0, 0, 0, 0, 0, 0);
    step("yw_second", 0, 1, 0, 0, 0, 1, 32'h600, 8'h03, 8'h14, 1, 32'h500, 0, 0, 0, 0);
    step("yw_land", 0, 0, 0, 0, 0, 0, 0, 8'h00, 8'h04, 1, 32'h600, 0, 0, 0, 0);
    step("yw_done", 0, 0, 0, 0, 0, 0, 0, 8'h00, 8'h00, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk);
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL drain actual=%0d required=0 pending entries", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
